// File: rtl/contador_pkg.sv
// Shared types for the parameterised up/down counter: operating modes and FSM states.
package contador_pkg;

    typedef enum logic [1:0] {
        WRAP    = 2'd0,
        SAT     = 2'd1,
        ONESHOT = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The unused encoding 3 falls back to WRAP.
    function automatic mode_e decode_mode(input logic [1:0] m);
        case (m)
            2'd1:    return SAT;
            2'd2:    return ONESHOT;
            default: return WRAP;
        endcase
    endfunction

endpackage

// File: rtl/contador_prescaler.sv
// Counts enabled cycles and raises tick on every PRESCALE-th one; clr restarts the count.
module contador_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    // At least one bit so PRESCALE=1 still elaborates; the counter then stays at 0.
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt == LAST);

endmodule

// File: rtl/contador_param.sv
// Parameterised up/down counter with WRAP/SAT/ONESHOT boundary handling, prescaler and run FSM.
module contador_param
    import contador_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] val,
    output logic             tc,
    output logic             ovf,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];

    state_e           state;
    mode_e            mode_sel;
    logic             start_ok;
    logic             presc_en;
    logic             presc_clr;
    logic             tick;
    logic             step;
    logic             boundary;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] wrap_val;
    logic [WIDTH-1:0] preset_val;

    assign mode_sel     = decode_mode(mode);
    assign start_ok     = start && (state != RUN);
    assign presc_en     = en && (state == RUN);
    assign presc_clr    = load || stop || start_ok;
    // load and stop both pre-empt a step; a start during RUN does not.
    assign step         = tick && !load && !stop;
    assign boundary     = up_dn ? (val == MAX_V) : (val == '0);
    assign load_clamped = (load_val > MAX_V) ? MAX_V : load_val;
    assign step_val     = up_dn ? val + WIDTH'(1) : val - WIDTH'(1);
    assign wrap_val     = up_dn ? '0 : MAX_V;
    assign preset_val   = up_dn ? '0 : MAX_V;
    assign tc           = boundary;

    contador_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (presc_en),
        .clr  (presc_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            val   <= '0;
            ovf   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            ovf <= 1'b0;
            if (load) begin
                val <= load_clamped;
            end
            // stop still moves the FSM when load owns val in the same cycle
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (load) begin
                state <= state;
            end else if (start_ok) begin
                state <= RUN;
                busy  <= 1'b1;
                val   <= preset_val;
            end else if (step) begin
                if (boundary) begin
                    ovf <= 1'b1;
                    case (mode_sel)
                        SAT: begin
                            val <= val;
                        end
                        ONESHOT: begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end
                        default: begin
                            val <= wrap_val;
                        end
                    endcase
                end else begin
                    val <= step_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_contador_param.sv
// Directed bench for contador_param: three instances (PRESCALE 1, 2, 3) share one stimulus stream.
module tb_contador_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       up_dn = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [1:0] mode = 2'd0;

    logic [3:0] val1, val2, val3;
    logic       tc1, tc2, tc3;
    logic       ovf1, ovf2, ovf3;
    logic       busy1, busy2, busy3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    contador_param #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .up_dn(up_dn),
        .load(load), .load_val(load_val), .mode(mode),
        .val(val1), .tc(tc1), .ovf(ovf1), .busy(busy1)
    );

    contador_param #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .up_dn(up_dn),
        .load(load), .load_val(load_val), .mode(mode),
        .val(val2), .tc(tc2), .ovf(ovf2), .busy(busy2)
    );

    contador_param #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(3)) dut3 (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .up_dn(up_dn),
        .load(load), .load_val(load_val), .mode(mode),
        .val(val3), .tc(tc3), .ovf(ovf3), .busy(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; en = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0;
        load_val = 4'd0; up_dn = 1'b1; mode = 2'd0;
        cyc(2);
        rst = 1'b0;
    endtask

    initial begin
        int exp_v;

        // Reset state and idle hold
        do_reset();
        chk("rst val1", val1, 0);
        chk("rst val2", val2, 0);
        chk("rst val3", val3, 0);
        chk("rst busy1", busy1, 0);
        chk("rst ovf1", ovf1, 0);
        chk("rst tc up", tc1, 0);
        up_dn = 1'b0; #1;
        chk("rst tc down", tc1, 1);
        up_dn = 1'b1;
        en = 1'b1;
        cyc(3);
        chk("idle hold val", val1, 0);
        chk("idle hold busy", busy1, 0);

        // WRAP up, PRESCALE=1
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0;
        chk("wrap start val", val1, 0);
        chk("wrap start busy", busy1, 1);
        en = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            cyc(1);
            exp_v = k % 10;
            chk($sformatf("wrap k=%0d val", k), val1, exp_v);
            chk($sformatf("wrap k=%0d ovf", k), ovf1, (k == 10));
            chk($sformatf("wrap k=%0d tc", k), tc1, (exp_v == 9));
        end
        en = 1'b0;

        // SAT down after a load in IDLE
        do_reset();
        mode = 2'd1;
        load = 1'b1; load_val = 4'd2; cyc(1); load = 1'b0;
        chk("sat load val", val1, 2);
        chk("sat load busy", busy1, 0);
        up_dn = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("sat preset val", val1, 9);
        chk("sat preset busy", busy1, 1);
        en = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            exp_v = (k < 9) ? 9 - k : 0;
            chk($sformatf("sat k=%0d val", k), val1, exp_v);
            chk($sformatf("sat k=%0d ovf", k), ovf1, (k >= 10));
            chk($sformatf("sat k=%0d busy", k), busy1, 1);
            chk($sformatf("sat k=%0d tc", k), tc1, (exp_v == 0));
        end
        en = 1'b0;

        // ONESHOT up, PRESCALE=3
        do_reset();
        mode = 2'd2;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("one start val", val3, 0);
        chk("one start busy", busy3, 1);
        en = 1'b1;
        for (int k = 1; k <= 33; k++) begin
            cyc(1);
            exp_v = (k / 3 > 9) ? 9 : k / 3;
            chk($sformatf("one k=%0d val", k), val3, exp_v);
            chk($sformatf("one k=%0d ovf", k), ovf3, (k == 30));
            chk($sformatf("one k=%0d busy", k), busy3, (k < 30));
        end
        start = 1'b1; cyc(1); start = 1'b0;
        chk("one restart val", val3, 0);
        chk("one restart busy", busy3, 1);
        chk("one restart ovf", ovf3, 0);
        en = 1'b0;

        // load + stop + start together during RUN
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0;
        en = 1'b1;
        cyc(3);
        chk("prio pre val", val1, 3);
        load = 1'b1; load_val = 4'd15; stop = 1'b1; start = 1'b1;
        cyc(1);
        load = 1'b0; stop = 1'b0; start = 1'b0;
        chk("prio val", val1, 9);
        chk("prio busy", busy1, 0);
        chk("prio tc", tc1, 1);
        cyc(3);
        chk("prio hold val", val1, 9);
        chk("prio hold busy", busy1, 0);
        en = 1'b0;

        // Reserved mode acts as WRAP; load in RUN; up_dn change mid-run
        do_reset();
        mode = 2'd3; up_dn = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0;
        chk("rsv preset val", val1, 9);
        en = 1'b1; load = 1'b1; load_val = 4'd0;
        cyc(1);
        load = 1'b0;
        chk("rsv load val", val1, 0);
        chk("rsv load ovf", ovf1, 0);
        chk("rsv load busy", busy1, 1);
        cyc(1);
        chk("rsv wrap val", val1, 9);
        chk("rsv wrap ovf", ovf1, 1);
        up_dn = 1'b1;
        cyc(1);
        chk("dir flip val", val1, 0);
        chk("dir flip ovf", ovf1, 1);
        cyc(1);
        chk("dir flip next val", val1, 1);
        chk("dir flip next ovf", ovf1, 0);
        en = 1'b0;

        // Asynchronous reset mid-run
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0;
        en = 1'b1;
        cyc(5);
        chk("arst pre val", val1, 5);
        chk("arst pre busy", busy1, 1);
        rst = 1'b1; #1;
        chk("arst val", val1, 0);
        chk("arst busy", busy1, 0);
        chk("arst ovf", ovf1, 0);
        cyc(1);
        rst = 1'b0;
        cyc(3);
        chk("arst wait val", val1, 0);
        chk("arst wait busy", busy1, 0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("arst restart busy", busy1, 1);
        chk("arst restart val", val1, 0);
        cyc(2);
        chk("arst resume val", val1, 2);
        en = 1'b0;

        // en toggling every cycle, PRESCALE=2
        do_reset();
        start = 1'b1; cyc(1); start = 1'b0;
        chk("gate start val", val2, 0);
        for (int k = 1; k <= 16; k++) begin
            en = (k % 2 == 1);
            cyc(1);
            chk($sformatf("gate k=%0d val", k), val2, (k + 1) / 4);
        end
        en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
